// File: rtl/fp32_div_seq.sv
// Sequential FP32 divider: result = a / b, 26-step restoring mantissa divide,
// round-to-nearest-even, subnormals flushed, fixed latency including special cases.
module fp32_div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_DIVIDE = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  logic [2:0]        r_state;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [23:0]       r_mb;
  logic [25:0]       r_rem;
  logic [25:0]       r_q;
  logic [4:0]        r_cnt;
  logic              r_spec;
  logic [31:0]       r_spec_res;
  logic              r_spec_dbz;
  logic              r_out_valid;
  logic [31:0]       r_result;
  logic              r_dbz;

  // Operand unpack and classification (exponent 0 is flushed to zero)
  logic [7:0]        w_ea;
  logic [7:0]        w_eb;
  logic [22:0]       w_fa;
  logic [22:0]       w_fb;
  logic [23:0]       w_ma;
  logic [23:0]       w_mb;
  logic              w_a_zero;
  logic              w_b_zero;
  logic              w_a_inf;
  logic              w_b_inf;
  logic              w_a_nan;
  logic              w_b_nan;
  logic              w_sign;
  logic              w_a_lt;
  logic signed [9:0] w_exp_raw;

  assign w_ea      = r_a[30:23];
  assign w_eb      = r_b[30:23];
  assign w_fa      = r_a[22:0];
  assign w_fb      = r_b[22:0];
  assign w_ma      = {1'b1, w_fa};
  assign w_mb      = {1'b1, w_fb};
  assign w_a_zero  = (w_ea == 8'h00);
  assign w_b_zero  = (w_eb == 8'h00);
  assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_sign    = r_a[31] ^ r_b[31];
  assign w_a_lt    = (w_ma < w_mb);
  assign w_exp_raw = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

  logic        w_spec;
  logic [31:0] w_spec_res;
  logic        w_spec_dbz;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_res = 32'd0;
    w_spec_dbz = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_spec_res = QNAN;
    end else if (w_a_inf) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_zero) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
      w_spec_dbz = 1'b1;
    end else if (w_a_zero || w_b_inf) begin
      w_spec_res = {w_sign, 31'd0};
    end else begin
      w_spec     = 1'b0;
    end
  end

  // One restoring step: compare, subtract, then double the residual
  logic        w_ge;
  logic [25:0] w_rem_sub;
  logic [25:0] w_rem_next;
  logic [25:0] w_q_next;

  assign w_ge       = (r_rem >= {2'b00, r_mb});
  assign w_rem_sub  = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
  assign w_rem_next = {w_rem_sub[24:0], 1'b0};
  assign w_q_next   = {r_q[24:0], w_ge};

  // Rounding and packing
  logic              w_guard;
  logic              w_rnd;
  logic              w_sticky;
  logic              w_up;
  logic [24:0]       w_man_sum;
  logic [23:0]       w_man;
  logic signed [9:0] w_exp_rnd;
  logic [31:0]       w_packed;
  logic [31:0]       w_final;

  assign w_guard   = r_q[1];
  assign w_rnd     = r_q[0];
  assign w_sticky  = (r_rem != 26'd0);
  assign w_up      = w_guard && (w_rnd || w_sticky || r_q[2]);
  assign w_man_sum = {1'b0, r_q[25:2]} + {24'd0, w_up};
  assign w_man     = w_man_sum[24] ? 24'h800000 : w_man_sum[23:0];
  assign w_exp_rnd = r_exp + $signed({9'd0, w_man_sum[24]});

  always_comb begin
    if (w_exp_rnd >= 10'sd255) begin
      w_packed = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_rnd <= 10'sd0) begin
      w_packed = {r_sign, 31'd0};
    end else begin
      w_packed = {r_sign, w_exp_rnd[7:0], w_man[22:0]};
    end
  end

  assign w_final = r_spec ? r_spec_res : w_packed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_sign      <= 1'b0;
      r_exp       <= 10'sd0;
      r_mb        <= 24'd0;
      r_rem       <= 26'd0;
      r_q         <= 26'd0;
      r_cnt       <= 5'd0;
      r_spec      <= 1'b0;
      r_spec_res  <= 32'd0;
      r_spec_dbz  <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_sign     <= w_spec ? w_spec_res[31] : w_sign;
          r_mb       <= w_mb;
          // Pre-normalise so the quotient lands in [1,2)
          r_rem      <= w_a_lt ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
          r_exp      <= w_a_lt ? (w_exp_raw - 10'sd1) : w_exp_raw;
          r_q        <= 26'd0;
          r_cnt      <= 5'd0;
          r_spec     <= w_spec;
          r_spec_res <= w_spec_res;
          r_spec_dbz <= w_spec_dbz;
          r_state    <= ST_DIVIDE;
        end
        ST_DIVIDE: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          if (r_cnt == 5'd25) begin
            r_state <= ST_ROUND;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_ROUND: begin
          r_result    <= w_final;
          r_dbz       <= r_spec & r_spec_dbz;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/fp32_div_seq.md
# fp32_div_seq

Sequential IEEE-754 single-precision divider, result = a / b. It is the inverse-operation companion to the combinational FP32 multiply/FMA datapath and sits beside it in the FP unit. Operands are accepted on a valid/ready handshake. The mantissa quotient is produced by a 26-iteration restoring divider, then rounded to nearest-even. The result is held on a valid/ready output until it is consumed.

## Interface
- No parameters; widths are fixed at FP32.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b present.
- in_ready  output  1  divider idle, can accept.
- a  input  32  dividend, FP32.
- b  input  32  divisor, FP32.
- out_valid  output  1  result and div_by_zero valid.
- out_ready  input  1  consumer accepts result.
- result  output  32  quotient, FP32.
- div_by_zero  output  1  set when a is finite nonzero and b is zero.

## Operation
- States: IDLE, SETUP, DIVIDE, ROUND, DONE.
- in_ready = (state == IDLE).
- **IDLE**
  - On in_valid && in_ready, register a and b, then go to SETUP.
  - in_valid is ignored in every other state.
- **SETUP**
  - Unpack sign, exponent and mantissa. Mantissa is {1, frac}.
  - Exponent 0 (zero or subnormal) is treated as zero, i.e. inputs are flushed to zero.
  - Sign = sa ^ sb.
  - Classify special cases and latch the special result, in priority order:
    1. Either operand is NaN, or inf/inf, or 0/0: 32'h7FC00000. Sign is 0 and div_by_zero is 0.
    2. inf/finite: signed inf.
    3. finite-nonzero/0: signed inf with div_by_zero = 1.
    4. 0/nonzero, or finite/inf: signed zero.
  - Exponent arithmetic is 10-bit signed: e = ea - eb + 127.
  - If ma < mb: shift ma left by 1 and decrement e. This guarantees the quotient lies in [1,2).
  - Clear the 5-bit iteration counter, then go to DIVIDE.
- **DIVIDE**
  - One restoring step per cycle on a 26-bit partial remainder: rem = rem*2 (starting from ma), compare with mb, subtract if greater or equal, shift the quotient bit into q.
  - Run 26 cycles, producing q[25:0] with q[25] = 1.
  - After the 26th step go to ROUND.
  - DIVIDE runs even when a special case is latched, so latency is constant.
- **ROUND**
  - man = q[25:2], guard = q[1], round = q[0], sticky = (rem != 0).
  - Round up when guard && (round || sticky || man[0]).
  - A carry out of man sets man = 24'h800000 and increments e.
  - After rounding:
    - e >= 255: signed inf (32'h7F800000 | sign).
    - e <= 0: signed zero (subnormal results are flushed).
    - Otherwise pack {sign, e[7:0], man[22:0]}.
  - A latched special case overrides the packed result.
  - Register result and div_by_zero, set out_valid, go to DONE.
- **DONE**
  - result, div_by_zero and out_valid are held stable while out_ready = 0.
  - On out_valid && out_ready: clear out_valid and go to IDLE.
  - result keeps its last value after the handshake.
- **Reset** (asynchronous, any state, including mid-DIVIDE):
  - state = IDLE, out_valid = 0, result = 0, div_by_zero = 0, internal registers cleared.
  - in_ready = 1 after reset is released.
  - An aborted operation never produces out_valid.

## Timing
- Fixed latency for all operands, special cases included. With accept at rising edge k:
  - SETUP occupies edge k+1.
  - DIVIDE occupies edges k+2 through k+27.
  - ROUND occupies edge k+28; out_valid is high from edge k+28.
- in_ready is low from edge k until the edge that completes the output handshake.
- The next accept is possible at the edge after that, so minimum issue interval is 30 cycles with out_ready tied high.
- No combinational path from in_valid or out_ready to any output. in_ready depends on state only.

## Test plan
- a=32'h40C00000 (6.0), b=32'h40000000 (2.0), out_ready=1 -> result=32'h40400000, div_by_zero=0; out_valid rises exactly 28 edges after accept and stays high 1 cycle; in_ready returns high the following cycle.
- a=32'h3F800000, b=32'h40400000 (1/3) -> 32'h3EAAAAAB (round up via guard/sticky); a=32'h3F800000, b=32'h3F800000 -> 32'h3F800000 (the ma >= mb path with exact quotient).
- Special cases:
  - a=32'hBF800000, b=32'h00000000 -> 32'hFF800000, div_by_zero=1.
  - 0/0 -> 32'h7FC00000, div_by_zero=0.
  - a=32'h7F800000, b=32'h7F800000 -> 32'h7FC00000.
  - a=32'h40000000, b=32'h7F800000 -> 32'h00000000.
  - All with 28-cycle latency.
- Overflow and underflow:
  - a=32'h7F7FFFFF, b=32'h3F000000 -> 32'h7F800000.
  - a=32'h00800000, b=32'h40000000 -> 32'h00000000 (flush).
  - a=32'h00400000 (subnormal), b=32'h3F800000 -> 32'h00000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid and pulse in_valid with new operands meanwhile -> result/out_valid stable, in_ready=0, new operands ignored; raise out_ready -> single handshake, then the new operand accepted only when in_ready=1.
- Assert rst_n=0 asynchronously during DIVIDE (iteration 10) -> out_valid=0, result=0, in_ready=1 immediately after release; no stale out_valid; the next division (6.0/2.0) completes correctly.
